int_exec_unit: RTL

// Parametrised successor to the single-cycle integer ALU stage. It sits between the integer

---
 rtl/int_exec_unit_if.sv | 38 +++
 rtl/int_exec_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/int_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : int_exec_unit_if
// Purpose  : Groups the reservation-station issue handshake and the CDB result
//            handshake of the integer execution unit into one bundle.
// Ports    : i_rsv_valid/i_rsv_ready/i_rsv_opcode/i_rsv_tag/i_rsv_V_flatten
//            (issue side), o_cdb_valid/o_cdb_ready/o_cdb_tag/o_cdb_wdata
//            (result side).
// Modports : master - the environment (RS issuing, CDB arbiter draining)
//            slave  - the execution unit itself
// Revision : 1.0  initial release
// ============================================================================
interface int_exec_unit_if #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_OPCODE_INT     = 4,
  parameter int BW_TAG            = 3
);
  logic                           i_rsv_valid;
  logic                           i_rsv_ready;
  logic [BW_OPCODE_INT-1:0]       i_rsv_opcode;
  logic [BW_TAG-1:0]              i_rsv_tag;
  logic [2*BW_PROCESSOR_DATA-1:0] i_rsv_V_flatten;
  logic                           o_cdb_valid;
  logic                           o_cdb_ready;
  logic [BW_TAG-1:0]              o_cdb_tag;
  logic [BW_PROCESSOR_DATA-1:0]   o_cdb_wdata;

  modport master (
    output i_rsv_valid, i_rsv_opcode, i_rsv_tag, i_rsv_V_flatten, o_cdb_ready,
    input  i_rsv_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata
  );

  modport slave (
    input  i_rsv_valid, i_rsv_opcode, i_rsv_tag, i_rsv_V_flatten, o_cdb_ready,
    output i_rsv_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata
  );
endinterface
`default_nettype wire

// File: rtl/int_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : int_exec_unit
// Purpose  : Integer execution stage between the reservation station and the
//            CDB arbiter. Single-cycle ALU ops plus an iterative shift-add
//            multiplier (MUL/MULH/MULHU) retiring MUL_BITS_PER_CYC multiplier
//            bits per cycle. One op in flight; the result is held until the
//            CDB takes it. i_flush kills the in-flight op and held result.
// Ports    : clk     - clock, rising edge
//            rst_n   - asynchronous active-low reset
//            i_flush - synchronous pipeline flush
//            bus     - issue/result handshake bundle (slave modport)
// Revision : 1.0  initial release
// ============================================================================
module int_exec_unit #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_OPCODE_INT     = 4,
  parameter int BW_TAG            = 3,
  parameter int MUL_BITS_PER_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_flush,
  int_exec_unit_if.slave bus
);

  localparam int BW    = BW_PROCESSOR_DATA;
  localparam int SHW   = $clog2(BW);
  localparam int ITERS = BW / MUL_BITS_PER_CYC;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  localparam logic [BW_OPCODE_INT-1:0] OP_SUB   = BW_OPCODE_INT'(1);
  localparam logic [BW_OPCODE_INT-1:0] OP_SLT   = BW_OPCODE_INT'(2);
  localparam logic [BW_OPCODE_INT-1:0] OP_XOR   = BW_OPCODE_INT'(3);
  localparam logic [BW_OPCODE_INT-1:0] OP_OR    = BW_OPCODE_INT'(4);
  localparam logic [BW_OPCODE_INT-1:0] OP_AND   = BW_OPCODE_INT'(5);
  localparam logic [BW_OPCODE_INT-1:0] OP_SLL   = BW_OPCODE_INT'(6);
  localparam logic [BW_OPCODE_INT-1:0] OP_SRA   = BW_OPCODE_INT'(7);
  localparam logic [BW_OPCODE_INT-1:0] OP_SRL   = BW_OPCODE_INT'(8);
  localparam logic [BW_OPCODE_INT-1:0] OP_SLTU  = BW_OPCODE_INT'(9);
  localparam logic [BW_OPCODE_INT-1:0] OP_MUL   = BW_OPCODE_INT'(11);
  localparam logic [BW_OPCODE_INT-1:0] OP_MULH  = BW_OPCODE_INT'(12);
  localparam logic [BW_OPCODE_INT-1:0] OP_MULHU = BW_OPCODE_INT'(13);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic                cdb_valid;
  logic [BW_TAG-1:0]   cdb_tag;
  logic [BW-1:0]       cdb_wdata;
  logic [2*BW-1:0]     acc;
  logic [2*BW-1:0]     mcand;
  logic [BW-1:0]       mplier;
  logic [CNT_W-1:0]    cnt;
  logic                neg_res;
  logic                hi_sel;

  logic [BW-1:0]       v0;
  logic [BW-1:0]       v1;
  logic [SHW-1:0]      shamt;
  logic [BW_OPCODE_INT-1:0] op;
  logic                is_mul;
  logic                is_mulh;
  logic                rsv_ready;
  logic                accept;
  logic [BW-1:0]       alu_result;
  logic [BW-1:0]       mag0;
  logic [BW-1:0]       mag1;
  logic [2*BW-1:0]     pp;
  logic [2*BW-1:0]     acc_next;
  logic [2*BW-1:0]     prod;
  logic [BW-1:0]       mul_result;

  assign op      = bus.i_rsv_opcode;
  assign v0      = bus.i_rsv_V_flatten[BW-1:0];
  assign v1      = bus.i_rsv_V_flatten[2*BW-1:BW];
  assign shamt   = v1[SHW-1:0];
  assign is_mulh = (op == OP_MULH);
  assign is_mul  = (op == OP_MUL) || is_mulh || (op == OP_MULHU);

  // A held result may be replaced in the same cycle the CDB drains it.
  assign rsv_ready = !i_flush &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && bus.o_cdb_ready));
  assign accept    = bus.i_rsv_valid && rsv_ready;

  assign bus.i_rsv_ready = rsv_ready;
  assign bus.o_cdb_valid = cdb_valid;
  assign bus.o_cdb_tag   = cdb_tag;
  assign bus.o_cdb_wdata = cdb_wdata;

  // Single-cycle ALU; ADD, AUIPC and the unused codes all fall through to V0+V1.
  always_comb begin
    alu_result = v0 + v1;
    case (op)
      OP_SUB:  alu_result = v0 - v1;
      OP_SLT:  alu_result = {{(BW-1){1'b0}}, ($signed(v0) < $signed(v1))};
      OP_XOR:  alu_result = v0 ^ v1;
      OP_OR:   alu_result = v0 | v1;
      OP_AND:  alu_result = v0 & v1;
      OP_SLL:  alu_result = v0 << shamt;
      OP_SRA:  alu_result = $unsigned($signed(v0) >>> shamt);
      OP_SRL:  alu_result = v0 >> shamt;
      OP_SLTU: alu_result = {{(BW-1){1'b0}}, (v0 < v1)};
      default: alu_result = v0 + v1;
    endcase
  end

  // MULH runs the unsigned datapath on magnitudes and fixes the sign at the end.
  // MUL keeps raw operands: the low half is identical for signed/unsigned.
  assign mag0 = (is_mulh && v0[BW-1]) ? (~v0 + 1'b1) : v0;
  assign mag1 = (is_mulh && v1[BW-1]) ? (~v1 + 1'b1) : v1;

  // Partial product for the multiplier bits retired this cycle.
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BITS_PER_CYC; j++) begin
      if (mplier[j]) pp = pp + (mcand << j);
    end
  end

  assign acc_next   = acc + pp;
  assign prod       = neg_res ? (~acc_next + 1'b1) : acc_next;
  assign mul_result = hi_sel ? prod[2*BW-1:BW] : prod[BW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_wdata <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg_res   <= 1'b0;
      hi_sel    <= 1'b0;
    end else if (i_flush) begin
      // tag/wdata intentionally keep their last values; valid gates them.
      state     <= ST_IDLE;
      cdb_valid <= 1'b0;
    end else if (accept) begin
      cdb_tag <= bus.i_rsv_tag;
      if (is_mul) begin
        state     <= ST_BUSY;
        cdb_valid <= 1'b0;
        acc       <= '0;
        cnt       <= CNT_LAST;
        mcand     <= {{BW{1'b0}}, mag0};
        mplier    <= mag1;
        neg_res   <= is_mulh && (v0[BW-1] ^ v1[BW-1]);
        hi_sel    <= (op != OP_MUL);
      end else begin
        state     <= ST_DONE;
        cdb_valid <= 1'b1;
        cdb_wdata <= alu_result;
      end
    end else begin
      case (state)
        ST_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BITS_PER_CYC;
          mplier <= mplier >> MUL_BITS_PER_CYC;
          if (cnt == '0) begin
            // Final iteration: commit using the not-yet-registered accumulator.
            state     <= ST_DONE;
            cdb_valid <= 1'b1;
            cdb_wdata <= mul_result;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.o_cdb_ready) begin
            state     <= ST_IDLE;
            cdb_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
